uart_ascii_rx: RTL and testbench

Serial 8N1 UART receiver that produces ASCII characters for the one-digit 7-segment display path. It replaces the free-running counter as the character source: each correctly framed byte updates a held 7-bit ASCII code plus a decimal-point flag, which the ASCII-to-7-segment decoder consumes directly. It runs in the 50 MHz board clock domain and samples an asynchronous RX pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_ascii_rx.sv | 153 +++++++++++++++
 tb/tb_uart_ascii_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, bit-period helper
// and the blank character shown before any byte has arrived.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_t;

    // ASCII space: decodes to an unlit digit.
    localparam logic [6:0] ASCII_BLANK = 7'h20;

    // Clock cycles per serial bit, truncated.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is a
// parameter so idle-high lines do not see a spurious edge on reset release.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_ascii_rx.sv
// 8N1 UART receiver producing a held 7-bit ASCII code plus decimal-point flag
// for the single-digit 7-segment display. Only correctly framed bytes update
// the held character.
module uart_ascii_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [6:0] ascii_out,
    output logic       dp_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    // Terminal counts: a period of N cycles ends when the counter reads N-1.
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    logic rx_s;

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;     // [2:0] index, [3] set after the 8th sample
    logic [7:0]    sh_q, sh_d;
    logic [6:0]    ascii_q, ascii_d;
    logic          dp_q, dp_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Frame FSM: next state, bit timing, shift register and output updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        ascii_d = ascii_q;
        dp_d    = dp_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 4'd1;
                    if (bit_d[3]) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        ascii_d = sh_q[6:0];
                        dp_d    = sh_q[7];
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Bad stop bit: keep the old character and wait out
                        // the low line so a break cannot look like a start.
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ascii_q <= ASCII_BLANK;
            dp_q    <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ascii_q <= ascii_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign ascii_out = ascii_q;
    assign dp_out    = dp_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_ascii_rx.sv
// Bench for uart_ascii_rx at CLKS_PER_BIT=16, HALF_BIT=8: a table of single
// frames plus hand-written back-to-back, framing-error, glitch and reset cases.
module tb_uart_ascii_rx;

    localparam int C       = 16;
    localparam int LATENCY = 8 + 9 * C + 1 + 2;   // rx fall to rx_valid

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [6:0] ascii_out;
    logic       dp_out;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_ascii_rx #(.CLK_FREQ(1600), .BAUD(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .ascii_out (ascii_out),
        .dp_out    (dp_out),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int both_cnt  = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;
    int last_ferr_cyc  = 0;
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
        end
        if (frame_err) begin
            ferr_cnt++;
            last_ferr_cyc = cyc;
        end
        if (rx_valid && frame_err) both_cnt++;
    end

    int checks = 0;
    int errors = 0;
    int fall_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Start bit and 8 data bits, LSB first; stop bit left to the caller.
    task automatic send_head(input logic [7:0] d);
        fall_cyc = cyc;
        send_bit(1'b0, C);
        for (int i = 0; i < 8; i++) send_bit(d[i], C);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_head(d);
        send_bit(1'b1, C);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [6:0] exp_ascii;
        logic       exp_dp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int v0;
        int f0;
        int fall1;
        vecs[0] = '{8'h41, 7'h41, 1'b0};
        vecs[1] = '{8'hC1, 7'h41, 1'b1};
        vecs[2] = '{8'h35, 7'h35, 1'b0};
        vecs[3] = '{8'h00, 7'h00, 1'b0};
        vecs[4] = '{8'hFF, 7'h7F, 1'b1};
        vecs[5] = '{8'hAA, 7'h2A, 1'b1};

        // Reset, then idle high for 50 clk.
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("reset ascii", ascii_out, 7'h20);
        check("reset dp", dp_out, 0);
        check("reset busy", busy, 0);
        check("reset pulses", valid_cnt + ferr_cnt, 0);

        // Table of isolated frames.
        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_byte(vecs[i].data);
            repeat (10) @(negedge clk);
            check($sformatf("vec%0d valid count", i), valid_cnt - v0, 1);
            check($sformatf("vec%0d latency", i), last_valid_cyc - fall_cyc, LATENCY);
            check($sformatf("vec%0d ascii", i), ascii_out, vecs[i].exp_ascii);
            check($sformatf("vec%0d dp", i), dp_out, vecs[i].exp_dp);
            check($sformatf("vec%0d busy", i), busy, 0);
            check($sformatf("vec%0d no frame_err", i), ferr_cnt - f0, 0);
            repeat (10) @(negedge clk);
        end

        // Back-to-back 0xC1 then 0x35.
        v0 = valid_cnt;
        send_byte(8'hC1);
        fall1 = fall_cyc;
        check("b2b mid ascii", ascii_out, 7'h41);
        check("b2b mid dp", dp_out, 1);
        send_byte(8'h35);
        check("b2b second fall spacing", fall_cyc - fall1, 10 * C);
        repeat (10) @(negedge clk);
        check("b2b valid count", valid_cnt - v0, 2);
        check("b2b pulse spacing", last_valid_cyc - prev_valid_cyc, 10 * C);
        check("b2b final ascii", ascii_out, 7'h35);
        check("b2b final dp", dp_out, 0);

        // 0x41 with the stop bit held low for 40 clk.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_head(8'h41);
        send_bit(1'b0, 40);
        check("ferr busy while low", busy, 1);
        check("ferr count", ferr_cnt - f0, 1);
        check("ferr latency", last_ferr_cyc - fall_cyc, LATENCY);
        send_bit(1'b1, 16);
        check("ferr busy after high", busy, 0);
        check("ferr no valid", valid_cnt - v0, 0);
        check("ferr ascii kept", ascii_out, 7'h35);
        check("ferr dp kept", dp_out, 0);

        // 4-clk low glitch on idle line.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0, 4);
        check("glitch busy during", busy, 1);
        send_bit(1'b1, 30);
        check("glitch busy after", busy, 0);
        check("glitch no pulses", (valid_cnt - v0) + (ferr_cnt - f0), 0);

        // Reset during bit 3 of 0x55, then a clean 0x55.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0, C);
        send_bit(1'b1, C);
        send_bit(1'b0, C);
        send_bit(1'b1, C);
        send_bit(1'b0, C / 2);
        check("pre-reset busy", busy, 1);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst ascii", ascii_out, 7'h20);
        check("rst dp", dp_out, 0);
        check("rst busy", busy, 0);
        repeat (30) @(negedge clk);
        check("rst no pulses", (valid_cnt - v0) + (ferr_cnt - f0), 0);
        send_byte(8'h55);
        repeat (10) @(negedge clk);
        check("post-rst valid count", valid_cnt - v0, 1);
        check("post-rst latency", last_valid_cyc - fall_cyc, LATENCY);
        check("post-rst ascii", ascii_out, 7'h55);
        check("post-rst dp", dp_out, 0);

        check("valid/ferr overlap", both_cnt, 0);
        check("total frame_err", ferr_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
